pet_key_sequencer: RTL and testbench

- Owns the PET keyboard matrix (10 rows x 8 columns, active-low) and shares it between two requesters.
- Requester 1 is the live PS/2 path: decoded {col,row} press/release events.
- Requester 2 is an injector path (OSD autotype/paste): events are queued in a FIFO and replayed by a hold/gap FSM, so each press and release persists across at least one PET scan.
- keyin drives the VIA keyboard input in place of a directly written key array.

---
 rtl/pet_key_sequencer.sv | 142 ++++++++++++++
 tb/tb_pet_key_sequencer.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pet_key_sequencer.sv
// pet_key_sequencer
//   Owns the PET 10x8 active-low keyboard matrix and shares it between the live
//   PS/2 path and an injector (autotype/paste) path. Live events write live_m
//   directly. Injected events are queued in a FIFO and replayed by an
//   IDLE/APPLY/HOLD FSM so each press and release persists across PET scans.
//   The two matrices are ANDed onto keyin, which feeds the VIA keyboard input.
//
// Ports
//   clk, reset_n               clock (posedge), async active-low reset
//   live_stb/_release/_code    live event strobe, 1=release, {col[2:0],row[3:0]}
//   inj_valid/inj_ready        injector FIFO handshake
//   inj_release/inj_code       injector event payload (same encoding as live)
//   inj_flush                  drop the queue and release every injected key
//   keyrow / keyin             VIA row select / column bits (0 = pressed)
//   inj_busy                   queue non-empty or FSM not idle
//   live_any                   some live key is held (registered)
//
// Build option
//   PET_KEYSEQ_LIVE_LOCKOUT_EN : the injector FSM stays in IDLE while live_any=1,
//   so real typing holds off autotype. A hold in progress still completes.
module pet_key_sequencer #(
  parameter int FIFO_DEPTH  = 8,
  parameter int HOLD_CYCLES = 600000,
  parameter int HOLD_W      = 20
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       live_stb,
  input  logic       live_release,
  input  logic [6:0] live_code,
  input  logic       inj_valid,
  output logic       inj_ready,
  input  logic       inj_release,
  input  logic [6:0] inj_code,
  input  logic       inj_flush,
  input  logic [3:0] keyrow,
  output logic [7:0] keyin,
  output logic       inj_busy,
  output logic       live_any
);

  localparam int          AW    = $clog2(FIFO_DEPTH);
  localparam logic [3:0]  NROWS = 4'd10;
  localparam logic [AW:0] PTR_ONE = 1;
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = 1;

  typedef struct packed {
    logic       rel;
    logic [2:0] col;
    logic [3:0] row;
  } ev_t;

  typedef enum logic [1:0] {IDLE, APPLY, HOLD} state_t;

  logic [9:0][7:0] live_m, inj_m;
  ev_t             mem [FIFO_DEPTH];
  logic [AW:0]     wr_ptr, rd_ptr;
  state_t          state;
  ev_t             cur;
  logic [HOLD_W-1:0] hold_cnt;
  logic            empty, full, wr_en, go;

  // Extra pointer MSB separates full (MSBs differ) from empty (all equal).
  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign inj_ready = !full;
  // A write coinciding with a flush is dropped.
  assign wr_en     = inj_valid && !full && !inj_flush;
  assign inj_busy  = (state != IDLE) || !empty;

`ifdef PET_KEYSEQ_LIVE_LOCKOUT_EN
  assign go = !live_any;
`else
  assign go = 1'b1;
`endif

  // Rows past 9 do not exist on the PET; they read as all released.
  assign keyin = (keyrow < NROWS) ? (live_m[keyrow] & inj_m[keyrow]) : 8'hFF;

  // Live path: immediate write, no queueing.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      live_m   <= '1;
      live_any <= 1'b0;
    end else begin
      if (live_stb && (live_code[3:0] < NROWS))
        live_m[live_code[3:0]][live_code[6:4]] <= live_release;
      live_any <= ~&live_m;
    end
  end

  // FIFO storage carries no reset; validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= {inj_release, inj_code};
  end

  // Injector pointers, FSM and matrix.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      state    <= IDLE;
      cur      <= '0;
      hold_cnt <= '0;
      inj_m    <= '1;
    end else if (inj_flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      state    <= IDLE;
      hold_cnt <= '0;
      inj_m    <= '1;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_ONE;
      case (state)
        IDLE: begin
          if (!empty && go) begin
            cur    <= mem[rd_ptr[AW-1:0]];
            rd_ptr <= rd_ptr + PTR_ONE;
            state  <= APPLY;
          end
        end
        APPLY: begin
          // Non-existent rows are consumed without spending a hold period.
          if (cur.row >= NROWS) begin
            state <= IDLE;
          end else begin
            inj_m[cur.row][cur.col] <= cur.rel;
            hold_cnt <= HOLD_LOAD;
            state    <= HOLD;
          end
        end
        HOLD: begin
          if (hold_cnt == '0) state <= IDLE;
          else                hold_cnt <= hold_cnt - HOLD_ONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pet_key_sequencer.sv
// Scoreboard bench for pet_key_sequencer. Stimulus pushes expected responses;
// one monitor process pops and compares. u_dut uses a short hold for cycle-exact
// timing checks, u_dut2 a long hold so its FIFO can be filled while stalled;
// u_dut2 row 1 is watched for every change and compared in order.
module tb_pet_key_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n = 1'b0;
  logic       live_stb = 0, live_release = 0, inj_valid = 0, inj_release = 0, inj_flush = 0;
  logic [6:0] live_code = '0, inj_code = '0;
  logic [3:0] keyrow = '0;
  logic [7:0] keyin;
  logic       inj_ready, inj_busy, live_any;

  logic       live_stb2 = 0, live_release2 = 0, inj_valid2 = 0, inj_release2 = 0, inj_flush2 = 0;
  logic [6:0] live_code2 = '0, inj_code2 = '0;
  logic [3:0] keyrow2 = 4'd1;
  logic [7:0] kin2;
  logic       ready2, busy2, live_any2;

  pet_key_sequencer #(.FIFO_DEPTH(8), .HOLD_CYCLES(4), .HOLD_W(20)) u_dut (
    .clk(clk), .reset_n(reset_n), .live_stb(live_stb), .live_release(live_release),
    .live_code(live_code), .inj_valid(inj_valid), .inj_ready(inj_ready),
    .inj_release(inj_release), .inj_code(inj_code), .inj_flush(inj_flush),
    .keyrow(keyrow), .keyin(keyin), .inj_busy(inj_busy), .live_any(live_any));

  pet_key_sequencer #(.FIFO_DEPTH(8), .HOLD_CYCLES(200), .HOLD_W(20)) u_dut2 (
    .clk(clk), .reset_n(reset_n), .live_stb(live_stb2), .live_release(live_release2),
    .live_code(live_code2), .inj_valid(inj_valid2), .inj_ready(ready2),
    .inj_release(inj_release2), .inj_code(inj_code2), .inj_flush(inj_flush2),
    .keyrow(keyrow2), .keyin(kin2), .inj_busy(busy2), .live_any(live_any2));

  // kind: 0 keyin, 1 inj_ready, 2 inj_busy, 3 live_any, 5 measured value, 9 timeout
  typedef struct {
    string nm;
    int    kind;
    int    exp;
    int    act;
  } ent_t;

  ent_t       q1[$];
  logic [7:0] q2[$];
  logic [7:0] last2 = 8'hFF;
  logic       mon_req = 1'b0;
  int         checks = 0;
  int         errors = 0;

  always @(negedge clk) begin
    ent_t        e;
    logic [31:0] a;
    logic [7:0]  x;
    if (mon_req) begin
      while (q1.size() > 0) begin
        e = q1.pop_front();
        case (e.kind)
          0:       a = {24'd0, keyin};
          1:       a = {31'd0, inj_ready};
          2:       a = {31'd0, inj_busy};
          3:       a = {31'd0, live_any};
          default: a = e.act;
        endcase
        checks++;
        if (a !== e.exp) begin
          errors++;
          $display("FAIL %s: got %0h expected %0h", e.nm, a, e.exp);
        end
      end
    end
    if (reset_n === 1'b1 && kin2 !== last2) begin
      last2 = kin2;
      checks++;
      if (q2.size() == 0) begin
        errors++;
        $display("FAIL dut2_row1_unexpected: got %h expected no change", kin2);
      end else begin
        x = q2.pop_front();
        if (kin2 !== x) begin
          errors++;
          $display("FAIL dut2_row1_order: got %h expected %h", kin2, x);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic chk(string nm, int kind, int exp, int act = 0);
    q1.push_back('{nm, kind, exp, act});
  endtask

  task automatic sample();
    mon_req = 1'b1;
    @(negedge clk); #1;
    mon_req = 1'b0;
  endtask

  task automatic kin(string nm, int row, int exp);
    keyrow = row[3:0];
    chk(nm, 0, exp);
    sample();
  endtask

  task automatic tmo(string nm);
    chk(nm, 9, 1, 0);
    sample();
  endtask

  task automatic live_ev(logic rel, logic [6:0] code);
    live_release = rel;
    live_code    = code;
    live_stb     = 1'b1;
    step();
    live_stb     = 1'b0;
  endtask

  // Holds valid until ready, then spends the write edge; returns cycles waited.
  task automatic inj_push(bit d2, logic rel, logic [6:0] code, output int waited);
    waited = 0;
    if (d2) begin inj_valid2 = 1'b1; inj_release2 = rel; inj_code2 = code; end
    else    begin inj_valid  = 1'b1; inj_release  = rel; inj_code  = code; end
    while (!(d2 ? ready2 : inj_ready) && waited < 1000) begin
      step();
      waited++;
    end
    if (!(d2 ? ready2 : inj_ready)) begin
      inj_valid = 1'b0; inj_valid2 = 1'b0;
      tmo("push_timeout");
    end else begin
      step();
      inj_valid = 1'b0; inj_valid2 = 1'b0;
    end
  endtask

  task automatic wait_idle(int bud);
    int n = 0;
    while (inj_busy && n < bud) begin
      step();
      n++;
    end
    if (inj_busy) tmo("idle_timeout");
  endtask

  logic       orel [9] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
  logic [6:0] ocode[9] = '{7'h01, 7'h11, 7'h01, 7'h21, 7'h31, 7'h11, 7'h21, 7'h41, 7'h31};
  logic [7:0] oexp [9] = '{8'hFE, 8'hFC, 8'hFD, 8'hF9, 8'hF1, 8'hF3, 8'hF7, 8'hE7, 8'hEF};

  initial begin
    int w;
    int n;

    // Reset state
    step(); step();
    chk("rst_ready", 1, 1);    sample();
    chk("rst_busy", 2, 0);     sample();
    chk("rst_live_any", 3, 0); sample();
    kin("rst_keyin", 0, 'hFF);
    reset_n = 1'b1;
    step();
    for (int r = 0; r < 16; r++) kin($sformatf("sweep_row%0d", r), r, 'hFF);

    // Live path
    live_ev(1'b0, 7'h29);
    kin("live_press", 9, 'hFB);
    step();
    chk("live_any_set", 3, 1); sample();
    live_ev(1'b1, 7'h29);
    kin("live_release", 9, 'hFF);
    live_ev(1'b0, 7'h7F);
    kin("live_norow_r9", 9, 'hFF);
    kin("live_norow_r7", 7, 'hFF);
    chk("live_any_norow", 3, 0); sample();

    // Injector latency and hold spacing
    inj_push(1'b0, 1'b0, 7'h02, w);
    inj_push(1'b0, 1'b1, 7'h02, w);
    kin("inj_lat_pre", 2, 'hFF);
    step();
    kin("inj_lat_apply", 2, 'hFE);
    for (int k = 3; k <= 7; k++) begin
      step();
      kin($sformatf("inj_hold_c%0d", k), 2, 'hFE);
    end
    step();
    kin("inj_release_c8", 2, 'hFF);
    step(); step(); step();
    chk("busy_last_hold", 2, 1); sample();
    step();
    chk("busy_done", 2, 0); sample();

    // Live and injected overlap on the same key
    inj_push(1'b0, 1'b0, 7'h56, w);
    step(); step();
    kin("ovl_inj", 6, 'hDF);
    live_ev(1'b0, 7'h56);
    kin("ovl_both", 6, 'hDF);
    live_ev(1'b1, 7'h56);
    kin("ovl_live_rel", 6, 'hDF);
    inj_push(1'b0, 1'b1, 7'h56, w);
    wait_idle(50);
    kin("ovl_inj_rel", 6, 'hFF);

    // Flush mid-hold with a queued entry and a same-cycle write
    inj_push(1'b0, 1'b0, 7'h14, w);
    step(); step();
    kin("fl_hold", 4, 'hFD);
    inj_push(1'b0, 1'b0, 7'h15, w);
    inj_valid = 1'b1; inj_release = 1'b0; inj_code = 7'h16; inj_flush = 1'b1;
    step();
    inj_flush = 1'b0; inj_valid = 1'b0;
    kin("fl_row4", 4, 'hFF);
    chk("fl_busy", 2, 0);  sample();
    chk("fl_ready", 1, 1); sample();
    repeat (8) step();
    kin("fl_row5_dropped", 5, 'hFF);
    kin("fl_row6_dropped", 6, 'hFF);

`ifdef PET_KEYSEQ_LIVE_LOCKOUT_EN
    live_ev(1'b0, 7'h29);
    inj_push(1'b0, 1'b0, 7'h14, w);
    repeat (10) step();
    kin("lock_pending", 4, 'hFF);
    chk("lock_busy", 2, 1); sample();
    live_ev(1'b1, 7'h29);
    repeat (5) step();
    kin("lock_applied", 4, 'hFD);
    inj_push(1'b0, 1'b1, 7'h14, w);
    wait_idle(50);
`endif

    // FIFO fill and order on the long-hold instance
    inj_push(1'b1, 1'b0, 7'h00, w);
    step(); step(); step();
    for (int i = 0; i < 8; i++) begin
      q2.push_back(oexp[i]);
      inj_push(1'b1, orel[i], ocode[i], w);
    end
    chk("fifo_full_ready", 5, 0, int'(ready2)); sample();
    q2.push_back(oexp[8]);
    inj_push(1'b1, orel[8], ocode[8], w);
    chk("fifo_9th_wait", 5, 192, w); sample();
    n = 0;
    while (q2.size() != 0 && n < 3000) begin
      step();
      n++;
    end
    if (q2.size() != 0) tmo("order_timeout");

    // Reset in the middle of a hold
    inj_push(1'b0, 1'b0, 7'h03, w);
    step(); step();
    kin("rmh_held", 3, 'hFE);
    q2.push_back(8'hFF);
    reset_n = 1'b0;
    kin("rmh_keyin", 3, 'hFF);
    chk("rmh_busy", 2, 0);  sample();
    chk("rmh_ready", 1, 1); sample();
    reset_n = 1'b1;
    step(); step();
    if (q2.size() != 0) tmo("rmh_dut2_timeout");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
